// File: rtl/recv_pkg.sv
// rtl/recv_pkg.sv - shared constants, pointer-width helper and stream record for recv_stream
package recv_pkg;

  localparam int RECV_DATA_W    = 8;
  localparam int RECV_BUF_DEPTH = 4;
  localparam int RECV_CNT_W     = 16;

  function automatic int RECV_PTR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic [RECV_DATA_W-1:0] data;
    logic                   valid;
  } recv_stream_t;

endpackage

// File: rtl/recv_skid_buf.sv
// rtl/recv_skid_buf.sv - circular skid buffer absorbing the FIFO read latency
module recv_skid_buf
  import recv_pkg::*;
#(
  parameter int DATA_W    = RECV_DATA_W,
  parameter int BUF_DEPTH = RECV_BUF_DEPTH,
  localparam int PTR_W    = RECV_PTR_W(BUF_DEPTH),
  localparam int OCC_W    = PTR_W + 1
) (
  input  logic              clk_r,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage is cleared too so the head reads 0 straight out of reset.
  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (!push && pop) occ <= occ - OCC_W'(1);
    end
  end

  assign head = mem[rd_ptr];

  // The credit check upstream makes these unreachable; they guard the bookkeeping.
  a_no_overflow: assert property (@(posedge clk_r) disable iff (reset)
    !(push && !pop && occ == OCC_W'(BUF_DEPTH)));
  a_no_underflow: assert property (@(posedge clk_r) disable iff (reset)
    !(pop && occ == '0));

endmodule

// File: rtl/recv_stream.sv
// rtl/recv_stream.sv - FIFO read-side receiver: credit-based reads, skid buffer, valid/ready output
module recv_stream
  import recv_pkg::*;
#(
  parameter int DATA_W    = RECV_DATA_W,
  parameter int BUF_DEPTH = RECV_BUF_DEPTH,
  parameter int CNT_W     = RECV_CNT_W,
  parameter int ZERO_FILL = 1
) (
  input  logic              clk_r,
  input  logic              reset,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  starve_cnt
);

  localparam int OCC_W = RECV_PTR_W(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  credit;
  logic              inflight;
  logic              pop;
  logic [DATA_W-1:0] head;

  // In-flight reads already own a slot; no credit is taken for a same-cycle pop.
  assign credit    = occ + OCC_W'(inflight);
  assign rd_en     = !reset && !empty && (credit < OCC_W'(BUF_DEPTH));
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = (ZERO_FILL != 0 && !out_valid) ? '0 : head;

  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= rd_en;
  end

  recv_skid_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk_r     (clk_r),
    .reset     (reset),
    .push      (inflight),
    .push_data (rd_data),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (clr_stats) begin
      starve_cnt <= '0;
    end else if (out_ready && !out_valid && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_recv_stream.sv
// tb/tb_recv_stream.sv - table vectors, directed corners and random traffic against a count-based model
module tb_recv_stream;

  logic       clk_r = 1'b0;
  logic       reset = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] rd_data = '0;
  logic       rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       clr_stats = 1'b0;
  logic [2:0] starve_cnt;

  always #5 clk_r = ~clk_r;

  recv_stream #(.DATA_W(8), .BUF_DEPTH(4), .CNT_W(3), .ZERO_FILL(1)) dut (
    .clk_r      (clk_r),
    .reset      (reset),
    .empty      (empty),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_stats  (clr_stats),
    .starve_cnt (starve_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Model: words issued minus words popped is everything owned by the receiver.
  int         issued;
  int         popped;
  logic       last_rd;
  logic [7:0] exp_q[$];
  logic [2:0] cnt_m;
  logic [7:0] pend_word;
  bit         seq_mode;
  int         seq_k;

  typedef struct {
    logic       rst;
    logic       e, r, c;
    logic       rd, v;
    logic [7:0] d;
    logic [2:0] s;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    issued = 0; popped = 0; last_rd = 1'b0; cnt_m = '0; seq_k = 0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1; empty = 1'b1; out_ready = 1'b0; clr_stats = 1'b0;
    @(posedge clk_r); #1;
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_starve", 32'(starve_cnt), 0);
    @(posedge clk_r); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic e, input logic r, input logic c, input int tidx);
    logic rd_m, valid_m;
    logic [7:0] data_m;
    empty = e; out_ready = r; clr_stats = c;
    rd_data = last_rd ? pend_word : 8'($urandom);
    @(negedge clk_r);
    valid_m = (issued - (last_rd ? 1 : 0) - popped) > 0;
    rd_m    = !e && (issued - popped) < 4;
    data_m  = valid_m ? exp_q[0] : 8'h00;
    chk("rd_en", 32'(rd_en), 32'(rd_m));
    chk("out_valid", 32'(out_valid), 32'(valid_m));
    chk("out_data", 32'(out_data), 32'(data_m));
    chk("starve_cnt", 32'(starve_cnt), 32'(cnt_m));
    if (tidx >= 0) begin
      chk($sformatf("tbl%0d_rd_en", tidx), 32'(rd_en), 32'(tbl[tidx].rd));
      chk($sformatf("tbl%0d_valid", tidx), 32'(out_valid), 32'(tbl[tidx].v));
      chk($sformatf("tbl%0d_data", tidx), 32'(out_data), 32'(tbl[tidx].d));
      chk($sformatf("tbl%0d_starve", tidx), 32'(starve_cnt), 32'(tbl[tidx].s));
    end
    @(posedge clk_r); #1;
    if (rd_m) begin
      issued++;
      pend_word = seq_mode ? 8'(8'h11 * (seq_k + 1)) : 8'($urandom);
      seq_k++;
      exp_q.push_back(pend_word);
    end
    last_rd = rd_m;
    if (valid_m && r) begin
      popped++;
      void'(exp_q.pop_front());
    end
    if (c) cnt_m = '0;
    else if (r && !valid_m && cnt_m != 3'd7) cnt_m = cnt_m + 3'd1;
  endtask

  initial begin
    // rst, empty, ready, clr | rd_en, valid, data, starve
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 3'd2};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 3'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 3'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 3'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 3'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 3'd0};

    seq_mode = 1'b1;
    pend_word = '0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) apply_reset();
      step(tbl[i].e, tbl[i].r, tbl[i].c, i);
    end

    // Empty toggling every other cycle with a willing sink.
    seq_mode = 1'b0;
    for (int i = 0; i < 24; i++) step(1'(i % 2), 1'b1, 1'b0, -1);

    // Starvation saturates at 7, then clear wins over a starving cycle.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, -1);
    chk("starve_sat", 32'(starve_cnt), 7);
    step(1'b1, 1'b1, 1'b1, -1);
    chk("starve_clr", 32'(starve_cnt), 0);
    step(1'b1, 1'b1, 1'b0, -1);

    // Async reset with occ=3 and a read in flight.
    seq_mode = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, -1);
    #2 reset = 1'b1;
    #1;
    chk("async_rd_en", 32'(rd_en), 0);
    chk("async_valid", 32'(out_valid), 0);
    chk("async_data", 32'(out_data), 0);
    chk("async_starve", 32'(starve_cnt), 0);
    @(posedge clk_r); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, -1);
    chk("post_rst_first", 32'(out_data), 32'h11);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, -1);

    // Random traffic.
    seq_mode = 1'b0;
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
